// File: rtl/half_sub_if.sv
// Bundle for the half subtractor: operand/qualifier inputs plus the
// combinational and registered result outputs.
interface half_sub_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             b;
  logic             in_valid;
  logic             cnt_clr;
  logic             diff;
  logic             borrow;
  logic             diff_q;
  logic             borrow_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;

  // Driver side: supplies operands, observes results.
  modport master (
    output a, b, in_valid, cnt_clr,
    input  diff, borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );

  // Subtractor side.
  modport slave (
    input  a, b, in_valid, cnt_clr,
    output diff, borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );
endinterface

// File: rtl/half_sub.sv
// 1-bit half subtractor (a - b). Combinational diff/borrow are always live;
// a valid-qualified registered copy and a saturating borrow-event counter
// sit alongside for clocked datapaths and status monitoring.
module half_sub #(
  parameter int unsigned CNT_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  half_sub_if.slave bus
);

  logic             diff_c;
  logic             borrow_c;

  logic             diff_reg_d,   diff_reg_q;
  logic             borrow_reg_d, borrow_reg_q;
  logic             valid_d,      valid_q;
  logic [CNT_W-1:0] cnt_d,        cnt_q;

  // Pure combinational arithmetic; independent of clock and reset.
  always_comb begin
    diff_c   = bus.a ^ bus.b;
    borrow_c = ~bus.a & bus.b;
  end

  // Next-state: capture on valid, otherwise hold; counter clear beats increment.
  always_comb begin
    diff_reg_d   = diff_reg_q;
    borrow_reg_d = borrow_reg_q;
    valid_d      = bus.in_valid;
    cnt_d        = cnt_q;
    if (bus.in_valid) begin
      diff_reg_d   = diff_c;
      borrow_reg_d = borrow_c;
    end
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (bus.in_valid && borrow_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg_q   <= 1'b0;
      borrow_reg_q <= 1'b0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      diff_reg_q   <= diff_reg_d;
      borrow_reg_q <= borrow_reg_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.diff       = diff_c;
  assign bus.borrow     = borrow_c;
  assign bus.diff_q     = diff_reg_q;
  assign bus.borrow_q   = borrow_reg_q;
  assign bus.out_valid  = valid_q;
  assign bus.borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_sub.sv
// Testbench for half_sub: combinational sweep, table-driven registered path
// and counter vectors, async reset mid-stream, and saturation on a 2-bit counter.
module tb_half_sub;

  logic clk;
  logic clk_en;
  logic rst_n;

  int n_checks;
  int n_fail;

  half_sub_if #(.CNT_W(8)) bus ();
  half_sub_if #(.CNT_W(2)) sbus ();

  half_sub #(.CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  half_sub #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       v;
    logic       clr;
    logic       ed;
    logic       eb;
    logic       edq;
    logic       ebq;
    logic       eov;
    logic [7:0] ecnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic a, input logic b, input logic v, input logic clr,
                              input logic ed, input logic eb, input logic edq,
                              input logic ebq, input logic eov, input logic [7:0] ecnt);
    vec_t r;
    r.a = a; r.b = b; r.v = v; r.clr = clr;
    r.ed = ed; r.eb = eb; r.edq = edq; r.ebq = ebq; r.eov = eov; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hard stop in case anything stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ab;
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.a = 0; bus.b = 0; bus.in_valid = 0; bus.cnt_clr = 0;
    sbus.a = 0; sbus.b = 1; sbus.in_valid = 0; sbus.cnt_clr = 1;

    //                a  b  v clr  d  br dq bq ov cnt
    vecs[0]  = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd1); // first accepted sample
    vecs[1]  = mk(0, 0, 0, 0,   0, 0, 1, 1, 0, 8'd1); // invalid: hold, ov drops
    vecs[2]  = mk(1, 1, 0, 1,   0, 0, 1, 1, 0, 8'd0); // clear counter
    vecs[3]  = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd1);
    vecs[4]  = mk(1, 0, 1, 0,   1, 0, 1, 0, 1, 8'd1);
    vecs[5]  = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd2);
    vecs[6]  = mk(1, 1, 1, 0,   0, 0, 0, 0, 1, 8'd2);
    vecs[7]  = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd3);
    vecs[8]  = mk(0, 1, 0, 0,   1, 1, 1, 1, 0, 8'd3); // same pattern, not valid
    vecs[9]  = mk(1, 0, 0, 0,   1, 0, 1, 1, 0, 8'd3);
    vecs[10] = mk(0, 1, 0, 0,   1, 1, 1, 1, 0, 8'd3);
    vecs[11] = mk(1, 1, 0, 0,   0, 0, 1, 1, 0, 8'd3);
    vecs[12] = mk(0, 1, 0, 0,   1, 1, 1, 1, 0, 8'd3);
    vecs[13] = mk(0, 1, 1, 1,   1, 1, 1, 1, 1, 8'd0); // clear beats increment
    vecs[14] = mk(0, 0, 1, 0,   0, 0, 0, 0, 1, 8'd0);
    vecs[15] = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd1);
    vecs[16] = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd2);
    vecs[17] = mk(0, 1, 1, 0,   1, 1, 1, 1, 1, 8'd3);
    vecs[18] = mk(1, 0, 0, 0,   1, 0, 1, 1, 0, 8'd3);

    // Reset state, clock idle.
    #3;
    check("rst_diff_q",   bus.diff_q,     0);
    check("rst_borrow_q", bus.borrow_q,   0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_borrow_cnt", bus.borrow_cnt, 0);

    // Combinational sweep with no clock and reset held.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      bus.a = ab[1];
      bus.b = ab[0];
      #10;
      check($sformatf("comb_diff_%0d", i),   bus.diff,   ab[1] ^ ab[0]);
      check($sformatf("comb_borrow_%0d", i), bus.borrow, ~ab[1] & ab[0]);
    end

    rst_n  = 1'b1;
    #2;
    clk_en = 1'b1;

    // Table-driven registered path and counter.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.a = vecs[i].a; bus.b = vecs[i].b;
      bus.in_valid = vecs[i].v; bus.cnt_clr = vecs[i].clr;
      #1;
      check($sformatf("v%0d_diff", i),   bus.diff,   vecs[i].ed);
      check($sformatf("v%0d_borrow", i), bus.borrow, vecs[i].eb);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_diff_q", i),    bus.diff_q,     vecs[i].edq);
      check($sformatf("v%0d_borrow_q", i),  bus.borrow_q,   vecs[i].ebq);
      check($sformatf("v%0d_out_valid", i), bus.out_valid,  vecs[i].eov);
      check($sformatf("v%0d_cnt", i),       bus.borrow_cnt, vecs[i].ecnt);
    end

    // Async reset between edges with cnt=3, diff_q=1.
    @(negedge clk);
    bus.in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_diff_q",    bus.diff_q,     0);
    check("arst_borrow_q",  bus.borrow_q,   0);
    check("arst_out_valid", bus.out_valid,  0);
    check("arst_cnt",       bus.borrow_cnt, 0);
    bus.a = 1; bus.b = 0;
    #1;
    check("arst_comb_diff_10",   bus.diff,   1);
    check("arst_comb_borrow_10", bus.borrow, 0);
    bus.a = 0; bus.b = 1; bus.in_valid = 1;
    #1;
    check("arst_comb_diff_01",   bus.diff,   1);
    check("arst_comb_borrow_01", bus.borrow, 1);
    @(posedge clk);
    #1;
    check("arst_held_cnt", bus.borrow_cnt, 0);
    check("arst_held_ov",  bus.out_valid,  0);

    // Release reset; first sample appears one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_pre_diff_q", bus.diff_q, 0);
    @(posedge clk);
    #1;
    check("rel_diff_q",    bus.diff_q,     1);
    check("rel_borrow_q",  bus.borrow_q,   1);
    check("rel_out_valid", bus.out_valid,  1);
    check("rel_cnt",       bus.borrow_cnt, 1);

    // Saturation on the 2-bit counter instance.
    @(negedge clk);
    bus.in_valid = 0;
    check("sat_start", sbus.borrow_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sbus.cnt_clr = 0; sbus.in_valid = 1; sbus.a = 0; sbus.b = 1;
      @(posedge clk);
      #1;
      check($sformatf("sat_cnt_%0d", i), sbus.borrow_cnt, (i < 3) ? i + 1 : 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/half_sub.md
Name: half_sub

Overview:
- 1-bit half subtractor computing a − b.
- Combinational outputs diff/borrow respond immediately to a/b with no clock needed.
- A registered, valid-qualified copy of the result plus a saturating borrow-event counter sits alongside, for use in clocked datapaths and status monitoring.
- Leaf arithmetic cell in the basic-logic library; building block for full subtractors and ripple-borrow subtractors.

Parameters:
- CNT_W, 8, width of the borrow-event counter borrow_cnt (≥1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  minuend bit.
- b  input  1  subtrahend bit.
- in_valid  input  1  qualifies a/b for the registered path; sampled on rising clk.
- diff  output  1  combinational difference, a XOR b.
- borrow  output  1  combinational borrow-out, (NOT a) AND b.
- diff_q  output  1  registered diff of last valid sample.
- borrow_q  output  1  registered borrow of last valid sample.
- out_valid  output  1  high for one cycle after an accepted sample.
- borrow_cnt  output  CNT_W  saturating count of accepted samples with borrow=1.
- cnt_clr  input  1  synchronous clear of borrow_cnt.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Combinational path:
  - diff = a ^ b; borrow = ~a & b.
  - Truth table (a,b → diff,borrow): 00→0,0; 01→1,1; 10→1,0; 11→0,0.
  - Zero latency; independent of clk, rst_n, in_valid. Must stay correct while rst_n is low or clk is idle/undriven.
- Reset, asynchronous on rst_n falling, held while low: diff_q=0, borrow_q=0, out_valid=0, borrow_cnt=0.
- Registered path, each rising clk with rst_n=1:
  - in_valid=1: diff_q←a^b, borrow_q←~a&b, out_valid←1.
  - in_valid=0: diff_q/borrow_q hold their value; out_valid←0.
  - Latency is exactly 1 cycle from accepted input to diff_q/borrow_q/out_valid.
- Counter:
  - On each rising clk, if cnt_clr=1: borrow_cnt←0. cnt_clr has priority over an increment in the same cycle.
  - Else if in_valid=1 and (~a&b)=1 and borrow_cnt≠all-ones: borrow_cnt←borrow_cnt+1.
  - Saturates at 2^CNT_W−1; never wraps.
- Reset mid-operation: registered outputs clear immediately, without waiting for a clock edge. First accepted sample after rst_n rises appears one cycle later.
- No X propagation from registered logic: outputs are defined from reset onward.

Test Plan:
- Combinational sweep, no clock: (a,b)=00,01,10,11 at 10 ns intervals → (diff,borrow)=(0,0),(1,1),(1,0),(0,0), each settled within the step.
- Registered latency: rst_n deasserted, in_valid=1 with a=0,b=1 on edge N → diff_q=1, borrow_q=1, out_valid=1 after edge N. On edge N+1 with in_valid=0 → out_valid=0, diff_q/borrow_q hold 1/1.
- Borrow counting: 5 valid samples (0,1),(1,0),(0,1),(1,1),(0,1) → borrow_cnt=3. Same pattern with in_valid=0 → count unchanged.
- Saturation: CNT_W=2, 6 valid (0,1) samples → borrow_cnt stays at 3 after the third increment.
- Clear priority: cnt_clr=1 with a valid (0,1) sample on the same edge → borrow_cnt=0.
- Async reset mid-stream: with borrow_cnt=3, diff_q=1, drive rst_n low between edges → all registered outputs 0 immediately. Combinational diff/borrow still track a/b during reset.
